// File: rtl/shift_deserializer_if.sv
// Bus bundle for the serial-to-parallel deserializer.
// The master side drives the serial stream and the consumer handshake;
// the slave side (the deserializer) returns the assembled word and status.
interface shift_deserializer_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic             e;
    logic             sin;
    logic             sin_valid;
    logic             msb_first;
    logic             out_ready;
    logic             clr_ovr;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             busy;
    logic             overrun;
    logic [CW-1:0]    bit_cnt;

    modport master (
        output e, sin, sin_valid, msb_first, out_ready, clr_ovr,
        input  out, out_valid, busy, overrun, bit_cnt
    );

    modport slave (
        input  e, sin, sin_valid, msb_first, out_ready, clr_ovr,
        output out, out_valid, busy, overrun, bit_cnt
    );
endinterface

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer with a one-word output register,
// valid/ready handshake and a sticky overrun flag.
//
// state | meaning
// IDLE  | no word in progress, bit_cnt = 0
// SHIFT | word partially received, 1 <= bit_cnt <= WIDTH-1
module shift_deserializer #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    shift_deserializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [WIDTH-1:0] word;
    logic             msb_lat, msb_nxt, msb_cur;
    logic [CW-1:0]    pos;
    logic             accept;
    logic             done;
    logic             drop;
    logic [WIDTH-1:0] out_q;
    logic             out_valid_q;
    logic             overrun_q;

    // State, bit counter, shifter and latched bit order register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            msb_lat <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            shreg   <= shreg_nxt;
            msb_lat <= msb_nxt;
        end
    end

    // Next-state logic: place the incoming bit and detect word completion
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        msb_nxt   = msb_lat;
        done      = 1'b0;
        accept    = bus.e & bus.sin_valid;
        // Bit order is taken from the first bit of a word and then frozen.
        msb_cur   = (state == IDLE) ? bus.msb_first : msb_lat;
        pos       = msb_cur ? (LAST - cnt) : cnt;
        word      = shreg;
        word[pos] = bus.sin;
        if (accept) begin
            case (state)
                IDLE: begin
                    msb_nxt = bus.msb_first;
                    if (cnt == LAST) begin
                        done      = 1'b1;
                        shreg_nxt = '0;
                    end else begin
                        state_nxt = SHIFT;
                        cnt_nxt   = cnt + CW'(1);
                        shreg_nxt = word;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        shreg_nxt = '0;
                    end else begin
                        cnt_nxt   = cnt + CW'(1);
                        shreg_nxt = word;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    shreg_nxt = '0;
                end
            endcase
        end
    end

    // A finished word is lost only if the previous one is still held and not taken now
    assign drop = done & out_valid_q & ~bus.out_ready;

    // Output word register, handshake and sticky overrun flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (done && !drop) begin
                out_q       <= word;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_ovr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state == SHIFT);
    assign bus.bit_cnt   = cnt;
endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer with a word-level reference model.
module tb_shift_deserializer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    shift_deserializer_if #(.WIDTH(W)) bus ();
    shift_deserializer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // reference model state
    int           m_cnt;
    bit           m_msb;
    bit           m_bits[W];
    logic [W-1:0] m_out;
    bit           m_valid;
    bit           m_ovr;

    // apply inputs, clock once, advance the model, settle past the edge
    task automatic cycle(input bit r, input bit e, input bit s, input bit sv,
                         input bit msb, input bit rdy, input bit clr);
        logic [W-1:0] w;
        bit done;
        rst = r; bus.e = e; bus.sin = s; bus.sin_valid = sv;
        bus.msb_first = msb; bus.out_ready = rdy; bus.clr_ovr = clr;
        @(posedge clk);
        done = 0;
        w = '0;
        if (!r) begin
            m_cnt = 0; m_out = '0; m_valid = 0; m_ovr = 0;
        end else begin
            if (e && sv) begin
                if (m_cnt == 0) m_msb = msb;
                m_bits[m_cnt] = s;
                m_cnt++;
                if (m_cnt == W) begin
                    for (int k = 0; k < W; k++) begin
                        if (m_msb) w[W-1-k] = m_bits[k];
                        else       w[k]     = m_bits[k];
                    end
                    done = 1;
                    m_cnt = 0;
                end
            end
            if (done && m_valid && !rdy) begin
                m_ovr = 1;
            end else begin
                if (done) begin
                    m_out = w; m_valid = 1;
                end else if (m_valid && rdy) begin
                    m_valid = 0;
                end
                if (clr) m_ovr = 0;
            end
        end
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input bit msb, input bit rdy_last);
        logic [7:0] v;
        v = w;
        for (int k = 0; k < W; k++)
            cycle(1, 1, msb ? v[W-1-k] : v[k], 1, msb, (k == W-1) ? rdy_last : 1'b0, 0);
    endtask

    task automatic test_reset();
        cycle(0, 1, 1, 1, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.out !== 8'h00 || bus.out_valid !== 1'b0 || bus.overrun !== 1'b0 ||
            bus.busy !== 1'b0 || bus.bit_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset: out=%h valid=%b ovr=%b busy=%b cnt=%0d, want 00/0/0/0/0",
                     bus.out, bus.out_valid, bus.overrun, bus.busy, bus.bit_cnt);
        end
    endtask

    task automatic test_lsb();
        bit pat[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
        for (int k = 0; k < 8; k++) begin
            cycle(1, 1, pat[k], 1, 0, 0, 0);
            checks++;
            if (bus.busy !== (k < 7) || bus.out_valid !== (k == 7)) begin
                errors++;
                $display("FAIL lsb_busy edge%0d: busy=%b valid=%b, want %b/%b",
                         k + 1, bus.busy, bus.out_valid, k < 7, k == 7);
            end
        end
        checks++;
        if (bus.out !== 8'h4D) begin
            errors++;
            $display("FAIL lsb_word: out=%h want 4d", bus.out);
        end
        cycle(1, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_msb();
        bit pat[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
        for (int k = 0; k < 8; k++) cycle(1, 1, pat[k], 1, 1, 0, 0);
        checks++;
        if (bus.out !== 8'hB2 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL msb_word: out=%h valid=%b want b2/1", bus.out, bus.out_valid);
        end
        cycle(1, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 8; k++) cycle(1, 1, pat[k], 1, (k < 3), 0, 0);
        checks++;
        if (bus.out !== 8'hB2) begin
            errors++;
            $display("FAIL msb_toggle: out=%h want b2", bus.out);
        end
        cycle(1, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_overrun();
        cycle(0, 0, 0, 0, 0, 0, 0);
        send_word(8'hA5, 0, 0);
        checks++;
        if (bus.out !== 8'hA5 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_first: out=%h valid=%b want a5/1", bus.out, bus.out_valid);
        end
        send_word(8'h3C, 0, 0);
        checks++;
        if (bus.out !== 8'hA5 || bus.overrun !== 1'b1 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_drop: out=%h ovr=%b valid=%b want a5/1/1",
                     bus.out, bus.overrun, bus.out_valid);
        end
        cycle(1, 0, 0, 0, 0, 0, 1);
        checks++;
        if (bus.overrun !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_clear: ovr=%b valid=%b want 0/1", bus.overrun, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        cycle(0, 0, 0, 0, 0, 0, 0);
        send_word(8'hA5, 0, 0);
        send_word(8'h3C, 0, 1);
        checks++;
        if (bus.out !== 8'h3C || bus.out_valid !== 1'b1 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL simul_consume: out=%h valid=%b ovr=%b want 3c/1/0",
                     bus.out, bus.out_valid, bus.overrun);
        end
        cycle(1, 0, 0, 0, 0, 1, 0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL consume: valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] v;
        v = 8'h5A;
        for (int k = 0; k < 8; k++) begin
            cycle(1, 1, v[k], 1, 0, 0, 0);
            cycle(1, 0, ~v[k], 1, 1, 0, 0);
            cycle(1, 1, ~v[k], 0, 1, 0, 0);
            checks++;
            if (bus.bit_cnt !== 3'((k + 1) % 8)) begin
                errors++;
                $display("FAIL gap_cnt bit%0d: cnt=%0d want %0d", k, bus.bit_cnt, (k + 1) % 8);
            end
        end
        checks++;
        if (bus.out !== 8'h5A || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL gap_word: out=%h valid=%b want 5a/1", bus.out, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) cycle(1, 1, 1'($urandom), 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            cycle(1, 1, 1, 1, 1, 0, 0);
            checks++;
            if (bus.out_valid !== (k == 7) || bus.bit_cnt !== 3'((k + 1) % 8)) begin
                errors++;
                $display("FAIL rst_mid bit%0d: valid=%b cnt=%0d want %b/%0d",
                         k, bus.out_valid, bus.bit_cnt, k == 7, (k + 1) % 8);
            end
        end
        checks++;
        if (bus.out !== 8'hFF) begin
            errors++;
            $display("FAIL rst_mid_word: out=%h want ff", bus.out);
        end
    endtask

    task automatic test_random();
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 59) != 0, $urandom_range(0, 4) != 0, 1'($urandom),
                  $urandom_range(0, 4) != 0, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 4) == 0);
            checks++;
            if (bus.out !== m_out || bus.out_valid !== m_valid || bus.overrun !== m_ovr ||
                bus.busy !== (m_cnt != 0) || bus.bit_cnt !== 3'(m_cnt)) begin
                errors++;
                $display("FAIL random cyc%0d: out=%h v=%b ovr=%b busy=%b cnt=%0d want %h/%b/%b/%b/%0d",
                         i, bus.out, bus.out_valid, bus.overrun, bus.busy, bus.bit_cnt,
                         m_out, m_valid, m_ovr, m_cnt != 0, m_cnt);
            end
        end
    endtask

    initial begin
        bus.e = 0; bus.sin = 0; bus.sin_valid = 0;
        bus.msb_first = 0; bus.out_ready = 0; bus.clr_ovr = 0;
        m_cnt = 0; m_msb = 0; m_out = '0; m_valid = 0; m_ovr = 0;
        test_reset();
        test_lsb();
        test_msb();
        test_overrun();
        test_back_to_back();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
